sync_fifo_ctrl: RTL

//  Single-clock, parametrised FIFO; same-domain counterpart of the crossbar's clock-crossing FIFO.

---
 rtl/sync_fifo_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with occupancy, thresholds, FWFT/registered read, sticky errors
// Arbitrary depth with explicit pointer wrap; every flag is decoded from the registered level.
module sync_fifo_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 1,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wpush,
  input  logic [DATA_SIZE-1:0]         wdata,
  output logic                         wfull,
  output logic                         wafull,
  input  logic                         rpop,
  output logic [DATA_SIZE-1:0]         rdata,
  output logic                         rvalid,
  output logic                         rempty,
  output logic                         raempty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_ctrl: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_ctrl: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
    $error("sync_fifo_ctrl: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_level;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign wfull     = (r_level == CW'(DEPTH));
  assign wafull    = (r_level >= CW'(AFULL_TH));
  assign rempty    = (r_level == '0);
  assign raempty   = (r_level <= CW'(AEMPTY_TH));
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Full+push+pop drops the push and empty+push+pop ignores the pop: no pass-through.
  assign w_push_ok = wpush & ~wfull;
  assign w_pop_ok  = rpop & ~rempty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A fresh error outranks a simultaneous clear.
      if (wpush && wfull) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rpop && rempty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata  = rempty ? '0 : r_mem[r_rptr];
    assign rvalid = ~rempty;
  end else begin : g_regrd
    logic [DATA_SIZE-1:0] r_rdata;
    logic                 r_rvalid;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_pop_ok;
        if (w_pop_ok) begin
          r_rdata <= r_mem[r_rptr];
        end
      end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
  end

endmodule
